// File: rtl/hsfir_tap_loader.sv
// Coefficient loader for the high-speed FIR tap chain: shifts a valid/ready
// coefficient packet into the chain and gates the sample strobe until the pipeline has flushed.
module hsfir_tap_loader #(
  parameter int TW    = 12,
  parameter int NTAPS = 64,
  parameter int LGN   = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [TW-1:0] s_data,
  input  logic          s_last,
  input  logic          i_ce,
  output logic          o_ce,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_busy,
  output logic          o_settled,
  output logic          o_err
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, SETTLE} state_t;

  localparam logic [LGN-1:0] LAST_N   = LGN'(NTAPS);
  localparam logic [LGN-1:0] SETTLE_N = LGN'(2 * NTAPS + 2);

  state_t         state, state_next;
  logic [LGN-1:0] n, c;
  logic [LGN-1:0] n_inc, c_inc;
  logic           accept;
  logic           shift_data, shift_zero, first_beat, set_err, count_ce, settle_done;

  assign s_ready = (state != PAD);
  assign accept  = s_valid && s_ready;
  assign o_ce    = i_ce && ((state == IDLE) || (state == SETTLE));
  assign o_busy  = (state != IDLE);
  assign n_inc   = n + LGN'(1);
  assign c_inc   = c + LGN'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_data  = 1'b0;
    shift_zero  = 1'b0;
    first_beat  = 1'b0;
    set_err     = 1'b0;
    count_ce    = 1'b0;
    settle_done = 1'b0;
    case (state)
      IDLE, SETTLE: begin
        if (accept) begin
          // A one-beat packet is short by definition; it still pads to NTAPS.
          first_beat = 1'b1;
          shift_data = 1'b1;
          set_err    = s_last;
          state_next = s_last ? PAD : LOAD;
        end else if ((state == SETTLE) && o_ce) begin
          count_ce = 1'b1;
          if (c_inc == SETTLE_N) begin
            settle_done = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          shift_data = 1'b1;
          if (n_inc == LAST_N) begin
            set_err    = !s_last;
            state_next = s_last ? SETTLE : DRAIN;
          end else if (s_last) begin
            set_err    = 1'b1;
            state_next = PAD;
          end
        end
      end
      PAD: begin
        shift_zero = 1'b1;
        if (n_inc == LAST_N) state_next = SETTLE;
      end
      DRAIN: begin
        if (accept && s_last) state_next = SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The settle count only lives while in SETTLE, so any exit or restart clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tap_wr  <= 1'b0;
      o_tap     <= '0;
      o_settled <= 1'b0;
      o_err     <= 1'b0;
      n         <= '0;
      c         <= '0;
    end else begin
      o_tap_wr <= shift_data || shift_zero;
      if (shift_data)      o_tap <= s_data;
      else if (shift_zero) o_tap <= '0;

      if (first_beat)                   n <= LGN'(1);
      else if (shift_data || shift_zero) n <= n_inc;

      if (state_next != SETTLE) c <= '0;
      else if (count_ce)        c <= c_inc;

      if (shift_data)       o_settled <= 1'b0;
      else if (settle_done) o_settled <= 1'b1;

      if (set_err)         o_err <= 1'b1;
      else if (first_beat) o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hsfir_tap_loader.sv
// Randomized bench for hsfir_tap_loader, checked every cycle against an
// event-timed packet model (tap-write schedule, pad window, settle pulse count).
module tb_hsfir_tap_loader;

  localparam int TW            = 12;
  localparam int NTAPS         = 4;
  localparam int LGN           = 8;
  localparam int SETTLE_PULSES = 2 * NTAPS + 2;

  logic          i_clk, i_reset;
  logic          s_valid, s_ready, s_last;
  logic [TW-1:0] s_data;
  logic          i_ce, o_ce, o_tap_wr, o_busy, o_settled, o_err;
  logic [TW-1:0] o_tap;

  hsfir_tap_loader #(.TW(TW), .NTAPS(NTAPS), .LGN(LGN)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .i_ce     (i_ce),
    .o_ce     (o_ce),
    .o_tap_wr (o_tap_wr),
    .o_tap    (o_tap),
    .o_busy   (o_busy),
    .o_settled(o_settled),
    .o_err    (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests, fails, t, ce_pct;
  bit checks_on, last_acc;

  // Packet-level model state
  bit            in_pkt, settle_active, exp_settled, exp_err;
  int            beats, cnt, settle_start, pad_lo, pad_hi;
  int            wr_cyc_q[$];
  logic [TW-1:0] wr_val_q[$];
  logic [TW-1:0] pkt_data[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, actual, expected);
    end
  endtask

  task automatic modelReset();
    in_pkt        = 1'b0;
    settle_active = 1'b0;
    exp_settled   = 1'b0;
    exp_err       = 1'b0;
    beats         = 0;
    cnt           = 0;
    settle_start  = 0;
    pad_lo        = -1;
    pad_hi        = -2;
    wr_cyc_q.delete();
    wr_val_q.delete();
  endtask

  task automatic checkCycle();
    bit exp_ready, exp_ce, exp_wr, acc;
    exp_ready = !(t >= pad_lo && t <= pad_hi);
    exp_ce    = i_ce && !(in_pkt || (settle_active && t < settle_start));
    exp_wr    = (wr_cyc_q.size() > 0) && (wr_cyc_q[0] == t);
    if (checks_on) begin
      checkOutput("s_ready", s_ready, exp_ready);
      checkOutput("o_ce", o_ce, exp_ce);
      checkOutput("o_tap_wr", o_tap_wr, exp_wr);
      if (exp_wr) checkOutput("o_tap", o_tap, wr_val_q[0]);
      checkOutput("o_settled", o_settled, exp_settled);
      checkOutput("o_err", o_err, exp_err);
      checkOutput("o_busy", o_busy, in_pkt || settle_active);
    end
    if (exp_wr) begin
      void'(wr_cyc_q.pop_front());
      void'(wr_val_q.pop_front());
    end
    acc = 1'b0;
    if (i_reset) begin
      modelReset();
      checks_on = 1'b1;
    end else begin
      acc = s_valid && exp_ready;
      if (acc) begin
        if (!in_pkt) begin
          in_pkt        = 1'b1;
          beats         = 1;
          exp_err       = 1'b0;
          settle_active = 1'b0;
          cnt           = 0;
        end else begin
          beats++;
        end
        exp_settled = 1'b0;
        if (beats <= NTAPS) begin
          wr_cyc_q.push_back(t + 1);
          wr_val_q.push_back(s_data);
        end
        if (beats == NTAPS && !s_last) exp_err = 1'b1;
        if (s_last) begin
          in_pkt        = 1'b0;
          settle_active = 1'b1;
          cnt           = 0;
          if (beats < NTAPS) begin
            exp_err      = 1'b1;
            pad_lo       = t + 1;
            pad_hi       = t + NTAPS - beats;
            settle_start = t + 1 + NTAPS - beats;
            for (int p = 0; p < NTAPS - beats; p++) begin
              wr_cyc_q.push_back(t + 2 + p);
              wr_val_q.push_back('0);
            end
          end else begin
            settle_start = t + 1;
          end
        end
      end else if (settle_active && t >= settle_start && exp_ce) begin
        cnt++;
        if (cnt == SETTLE_PULSES) begin
          exp_settled   = 1'b1;
          settle_active = 1'b0;
        end
      end
    end
    last_acc = acc;
    t++;
  endtask

  task automatic step();
    @(negedge i_clk);
    checkCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic driveCe();
    i_ce = ($urandom_range(99) < ce_pct);
  endtask

  task automatic makePacket(input int len);
    pkt_data.delete();
    for (int i = 0; i < len; i++) pkt_data.push_back(TW'($urandom));
  endtask

  task automatic applyStimulus(input int valid_pct, input bit with_last);
    int sent, budget;
    sent   = 0;
    budget = 0;
    while (sent < pkt_data.size() && budget < 200) begin
      s_valid = ($urandom_range(99) < valid_pct);
      s_data  = pkt_data[sent];
      s_last  = with_last && (sent == pkt_data.size() - 1);
      driveCe();
      step();
      if (last_acc) sent++;
      budget++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (budget >= 200) checkOutput("pkt_timeout", sent, pkt_data.size());
  endtask

  task automatic idleCycles(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      driveCe();
      step();
    end
  endtask

  initial begin
    tests = 0; fails = 0; t = 0; ce_pct = 100;
    checks_on = 1'b0; last_acc = 1'b0;
    modelReset();
    i_reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; i_ce = 1'b1;
    repeat (2) step();
    i_reset = 1'b0;
    checkOutput("rst_tap", o_tap, 0);
    checkOutput("rst_ready", s_ready, 1);
    idleCycles(2);

    // Correct packet, valid held high, strobe held high
    pkt_data = {12'h001, 12'h002, 12'h003, 12'h004};
    applyStimulus(100, 1'b1);
    idleCycles(12);
    checkOutput("full_settled", o_settled, 1);
    checkOutput("full_err", o_err, 0);

    // Short packet pads with zeros
    pkt_data = {12'h7FF, 12'h800};
    applyStimulus(100, 1'b1);
    idleCycles(12);
    checkOutput("short_err", o_err, 1);

    // Long packet drains extra beats
    makePacket(6);
    applyStimulus(100, 1'b1);
    idleCycles(12);
    checkOutput("long_err", o_err, 1);
    makePacket(NTAPS);
    applyStimulus(100, 1'b1);
    checkOutput("err_cleared", o_err, 0);
    idleCycles(12);

    // Restart a load halfway through settling
    makePacket(NTAPS);
    applyStimulus(100, 1'b1);
    idleCycles(4);
    makePacket(NTAPS);
    applyStimulus(100, 1'b1);
    checkOutput("restart_settled", o_settled, 0);
    idleCycles(9);
    checkOutput("restart_early", o_settled, 0);
    idleCycles(2);
    checkOutput("restart_done", o_settled, 1);

    // Reset in the middle of a load
    makePacket(2);
    applyStimulus(100, 1'b0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checkOutput("midrst_wr", o_tap_wr, 0);
    checkOutput("midrst_settled", o_settled, 0);
    checkOutput("midrst_ready", s_ready, 1);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_tap", o_tap, 0);
    makePacket(NTAPS);
    applyStimulus(100, 1'b1);
    idleCycles(12);
    checkOutput("midrst_reload", o_settled, 1);

    // Randomized packets, handshake gaps and strobe patterns
    repeat (60) begin
      makePacket($urandom_range(NTAPS + 2, 2));
      ce_pct = $urandom_range(100, 30);
      applyStimulus($urandom_range(100, 50), 1'b1);
      idleCycles($urandom_range(30, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
